digit_serial_alu: RTL and testbench
===================================

Name: digit_serial_alu

Overview:
Parametrised multi-cycle ALU built from a DIGIT-bit ALU slice that is reused over WIDTH/DIGIT cycles, LSB digit first.
- Operand conditioning: A-invert, B-invert, carry-in.
- Operations: AND, OR, ADD/SUB, SLT.
- Flags: carry, signed overflow, zero.
- Valid/ready handshake on both sides.
- Serves as the area-lean datapath ALU; the number of slices used trades against latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; DIGIT == WIDTH gives a single-cycle ALU.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset; one clock, synchronous, active-low.
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
a_invert  input  1  use ~a.
b_invert  input  1  use ~b.
carry_in  input  1  carry into bit 0 (1 with b_invert gives subtract).
op  input  2  00 AND, 01 OR, 10 ADD, 11 SLT.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
result  output  WIDTH  operation result.
carry_out  output  1  carry out of the MSB (ADD/SLT); 0 for AND/OR.
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB (ADD/SLT); 0 for AND/OR.
zero  output  1  result == 0.

Behaviour:
- Let N = WIDTH/DIGIT. If WIDTH % DIGIT != 0, elaboration fails with an error.
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n low at a clock edge):
  - state = IDLE, digit counter = 0, carry register = 0.
  - result = 0, carry_out = 0, overflow = 0, zero = 0, out_valid = 0.
  - in_ready = 1 once reset is applied.
  - Reset mid-RUN or mid-DONE aborts the operation; the partial result is discarded.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b, a_invert, b_invert, op; carry register = carry_in; counter = 0; go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle, process digit k = counter:
    - am = a_invert ? ~a[k] : a[k]; bm = b_invert ? ~b[k] : b[k].
    - AND/OR: bitwise.
    - ADD/SLT: am + bm + carry register; the carry register takes the digit carry-out.
  - Write the digit result into the result register at bits [k*DIGIT +: DIGIT].
  - On the last digit (counter == N-1):
    - Capture carry_out and overflow.
    - Compute zero from the final result.
    - Go to DONE.
  - Timing: accept on edge E0; digits on E1..EN; out_valid is high after EN. Latency is N cycles from accept to out_valid.
- DONE:
  - out_valid = 1; result and all flags held stable.
  - On out_ready: out_valid = 0, go to IDLE.
  - No new accept in the same cycle, so the initiation interval is N+2 cycles with out_ready tied high.
- result, carry_out, overflow and zero are only meaningful while out_valid = 1. Intermediate result bits may be visible during RUN.
- SLT:
  - Runs the full add. The final result is zero-extended {0, sum_msb XOR overflow}.
  - carry_out and overflow report the underlying add.
  - zero reflects the final SLT result.
  - Signed compare requires b_invert=1 and carry_in=1, which the caller supplies.
- No X is ever driven on any output.

Optional Feature:
Macro ALU_SLT_EN.
- Defined: op 11 performs SLT as above.
- Not defined: op 11 is a defined no-op.
  - Runs the normal N cycles.
  - result = 0, carry_out = 0, overflow = 0, zero = 1.
  - The SLT logic is not synthesised.

Decomposition:
- Package alu_pkg:
  - alu_op_e (2-bit enum: OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11).
  - FSM state enum alu_state_e (IDLE, RUN, DONE).
- Sub-module alu_digit: purely combinational DIGIT-bit slice.
  - Inputs: a, b, a_invert, b_invert, carry_in, op.
  - Outputs: digit result, carry out, carry into the digit MSB (used for overflow on the last digit).
- Top level contains the FSM, digit counter, carry register, operand/result registers and flag logic.

Test Plan (WIDTH=16, DIGIT=4):
1. ADD a=0x7FFF, b=0x0001, carry_in=0 -> result 0x8000, carry_out 0, overflow 1, zero 0; out_valid exactly 4 cycles after accept.
2. SUB a=0x0005, b=0x0005, b_invert=1, carry_in=1 -> result 0x0000, carry_out 1, overflow 0, zero 1.
3. Logic cases:
   - OR, a=0x00FF with a_invert, b=0x0F0F -> 0xFF0F.
   - AND, a_invert=b_invert=1 (NOR), a=0x00F0, b=0x000F -> 0xFF00, carry_out 0.
4. SLT (ALU_SLT_EN defined; b_invert=1, carry_in=1):
   - a=0xFFFE, b=0x0003 -> 0x0001.
   - a=0x0003, b=0xFFFE -> 0x0000.
   - a=0x8000, b=0x0001 (overflow case) -> 0x0001.
   - Same SLT ops without the macro -> result 0x0000, zero 1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> result/flags stable, in_ready 0, no accept. Then out_ready=1 -> in_ready=1 next cycle, the new op is accepted and produces the correct result.
6. Reset: rst_n low for 1 cycle after 2 RUN digits -> out_valid 0, in_ready 1, state IDLE. The following ADD 0x1234+0x1111 yields 0x2345 with no stale carry.

Source files
------------

// File: rtl/digit_serial_alu_pkg.sv
// Shared types for the digit-serial ALU: operation codes and FSM states.
// Optional SLT support is controlled by the ALU_SLT_EN macro in the slice and top.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_state_e;

endpackage

// File: rtl/digit_serial_alu_digit.sv
// Combinational DIGIT-bit ALU slice with operand inversion and carry chain.
// Macro ALU_SLT_EN: when undefined, OP_SLT yields zero result and zero carries.
module alu_digit
    import alu_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  alu_op_e          op,
    output logic [DIGIT-1:0] y,
    output logic             carry_out,
    output logic             carry_msb
);

    logic [DIGIT-1:0] am;
    logic [DIGIT-1:0] bm;
    logic [DIGIT:0]   sum;

    always_comb begin
        am        = a_invert ? ~a : a;
        bm        = b_invert ? ~b : b;
        sum       = {1'b0, am} + {1'b0, bm} + {{DIGIT{1'b0}}, carry_in};
        y         = '0;
        carry_out = 1'b0;
        carry_msb = 1'b0;
        case (op)
            OP_AND: y = am & bm;
            OP_OR:  y = am | bm;
`ifdef ALU_SLT_EN
            OP_ADD, OP_SLT: begin
`else
            OP_ADD: begin
`endif
                y         = sum[DIGIT-1:0];
                carry_out = sum[DIGIT];
                // Carry into the MSB recovered from the MSB sum bit; valid for DIGIT == 1 too.
                carry_msb = sum[DIGIT-1] ^ am[DIGIT-1] ^ bm[DIGIT-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/digit_serial_alu.sv
// Multi-cycle ALU reusing one DIGIT-bit slice over WIDTH/DIGIT cycles, LSB digit first.
// Macro ALU_SLT_EN enables op 11 (SLT); otherwise op 11 is a no-op returning zero.
module digit_serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic             carry_in,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_width
            $error("digit_serial_alu: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    alu_state_e       state, state_n;
    logic [CW-1:0]    cnt;
    logic             carry_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             ainv_r, binv_r;
    alu_op_e          op_r;

    logic [DIGIT-1:0] dig_y;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] res_n;
    logic             ovf_n;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a         (a_r[cnt*DIGIT +: DIGIT]),
        .b         (b_r[cnt*DIGIT +: DIGIT]),
        .a_invert  (ainv_r),
        .b_invert  (binv_r),
        .carry_in  (carry_r),
        .op        (op_r),
        .y         (dig_y),
        .carry_out (dig_cout),
        .carry_msb (dig_cmsb)
    );

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN:  if (cnt == LAST) state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        res_n = result;
        res_n[cnt*DIGIT +: DIGIT] = dig_y;
        ovf_n = dig_cmsb ^ dig_cout;
`ifdef ALU_SLT_EN
        // Only meaningful on the last digit, where dig_y holds the sum MSB.
        if (op_r == OP_SLT) begin
            res_n    = '0;
            res_n[0] = dig_y[DIGIT-1] ^ ovf_n;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            ainv_r    <= 1'b0;
            binv_r    <= 1'b0;
            op_r      <= OP_AND;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r     <= a;
                    b_r     <= b;
                    ainv_r  <= a_invert;
                    binv_r  <= b_invert;
                    op_r    <= alu_op_e'(op);
                    carry_r <= carry_in;
                    cnt     <= '0;
                end
                RUN: begin
                    result  <= res_n;
                    carry_r <= dig_cout;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        carry_out <= dig_cout;
                        overflow  <= ovf_n;
                        zero      <= (res_n == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed self-checking bench for digit_serial_alu (WIDTH=16, DIGIT=4).
// SLT expectations follow the ALU_SLT_EN macro the RTL is built with.
module tb_digit_serial_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        a_invert, b_invert, carry_in;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out, overflow, zero;

    int total = 0;
    int bad   = 0;

    digit_serial_alu #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_invert  (a_invert),
        .b_invert  (b_invert),
        .carry_in  (carry_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Present an operation, count cycles from accept to out_valid (bounded), capture outputs, release.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ai, input logic bi,
                          input logic ci, input logic [1:0] top, output int cyc,
                          output logic [15:0] r, output logic co, output logic ov, output logic z);
        @(negedge clk);
        a = ta; b = tb; a_invert = ai; b_invert = bi; carry_in = ci; op = top;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = result; co = carry_out; ov = overflow; z = zero;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        total++;
        if ({result, carry_out, overflow, zero} !== 19'd0) begin
            bad++; $display("FAIL reset_out: result=%h co=%b ov=%b z=%b want 0000/0/0/0",
                            result, carry_out, overflow, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int cyc; logic [15:0] r; logic co, ov, z;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b10, cyc, r, co, ov, z);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", cyc); end
        total++;
        if ({r, co, ov, z} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL add_ovf: r=%h co=%b ov=%b z=%b want 8000/0/1/0", r, co, ov, z);
        end
    endtask

    task automatic test_sub();
        int cyc; logic [15:0] r; logic co, ov, z;
        run_op(16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 2'b10, cyc, r, co, ov, z);
        total++;
        if (cyc !== 4 || {r, co, ov, z} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            bad++; $display("FAIL sub_zero: cyc=%0d r=%h co=%b ov=%b z=%b want 4/0000/1/0/1", cyc, r, co, ov, z);
        end
    endtask

    task automatic test_logic();
        int cyc; logic [15:0] r; logic co, ov, z;
        run_op(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b0, 2'b01, cyc, r, co, ov, z);
        total++;
        if (cyc !== 4 || {r, co, ov, z} !== {16'hFF0F, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL or_ainv: cyc=%0d r=%h co=%b ov=%b z=%b want 4/ff0f/0/0/0", cyc, r, co, ov, z);
        end
        run_op(16'h00F0, 16'h000F, 1'b1, 1'b1, 1'b1, 2'b00, cyc, r, co, ov, z);
        total++;
        if (cyc !== 4 || {r, co, ov, z} !== {16'hFF00, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL and_nor: cyc=%0d r=%h co=%b ov=%b z=%b want 4/ff00/0/0/0", cyc, r, co, ov, z);
        end
    endtask

    task automatic test_slt();
        int cyc; logic [15:0] r; logic co, ov, z;
        logic [15:0] va [3] = '{16'hFFFE, 16'h0003, 16'h8000};
        logic [15:0] vb [3] = '{16'h0003, 16'hFFFE, 16'h0001};
`ifdef ALU_SLT_EN
        logic [18:0] exp [3] = '{{16'h0001, 1'b1, 1'b0, 1'b0},
                                 {16'h0000, 1'b0, 1'b0, 1'b1},
                                 {16'h0001, 1'b1, 1'b1, 1'b0}};
`else
        logic [18:0] exp [3] = '{{16'h0000, 1'b0, 1'b0, 1'b1},
                                 {16'h0000, 1'b0, 1'b0, 1'b1},
                                 {16'h0000, 1'b0, 1'b0, 1'b1}};
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, 1'b1, 1'b1, 2'b11, cyc, r, co, ov, z);
            total++;
            if (cyc !== 4 || {r, co, ov, z} !== exp[i]) begin
                bad++; $display("FAIL slt_%0d: cyc=%0d r/co/ov/z=%h want 4/%h", i, cyc, {r, co, ov, z}, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [15:0] r; logic co, ov, z;
        @(negedge clk);
        a = 16'h0010; b = 16'h0020; a_invert = 0; b_invert = 0; carry_in = 0; op = 2'b10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        a = 16'h0100; b = 16'h0200; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0030 || zero !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d: ov=%b ir=%b r=%h z=%b want 1/0/0030/0",
                                i, out_valid, in_ready, result, zero);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        total++;
        if (cyc !== 4 || result !== 16'h0300 || carry_out !== 1'b0) begin
            bad++; $display("FAIL bp_next: cyc=%0d r=%h co=%b want 4/0300/0", cyc, result, carry_out);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int cyc; logic [15:0] r; logic co, ov, z;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; a_invert = 0; b_invert = 0; carry_in = 0; op = 2'b10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
            bad++; $display("FAIL mid_reset: out_valid=%b in_ready=%b r=%h want 0/1/0000", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 2'b10, cyc, r, co, ov, z);
        total++;
        if (cyc !== 4 || {r, co, ov, z} !== {16'h2345, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL post_reset_add: cyc=%0d r=%h co=%b ov=%b z=%b want 4/2345/0/0/0", cyc, r, co, ov, z);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_invert = 1'b0; b_invert = 1'b0; carry_in = 1'b0; op = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_slt();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
